// File: rtl/sr_pkg.sv
// Shared constants and state encoding for the SR_ff PWM command driver.
// Imported by the driver top level and its configuration double buffer.
package sr_pkg;

    localparam int SR_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sr_cfg_shadow.sv
// Period/duty double buffer: loads land in a shadow copy and are
// moved to the active copy only when the driver asserts apply.
module sr_cfg_shadow
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  logic             apply,
    output logic [WIDTH-1:0] per_a,
    output logic [WIDTH-1:0] duty_a,
    output logic             pending
);

    logic [WIDTH-1:0] period_sh;
    logic [WIDTH-1:0] duty_sh;

    // A load coincident with apply bypasses the shadow so it is used at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_sh <= '0;
            duty_sh   <= '0;
            per_a     <= '0;
            duty_a    <= '0;
            pending   <= 1'b0;
        end else if (apply && load) begin
            period_sh <= period;
            duty_sh   <= duty;
            per_a     <= period;
            duty_a    <= duty;
            pending   <= 1'b0;
        end else if (apply && pending) begin
            per_a     <= period_sh;
            duty_a    <= duty_sh;
            pending   <= 1'b0;
        end else if (load) begin
            period_sh <= period;
            duty_sh   <= duty;
            pending   <= 1'b1;
        end
    end

endmodule

// File: rtl/sr_pwm_driver.sv
// Generates set/reset pulse streams so a downstream SR flip-flop
// outputs PWM; s and r are mutually exclusive by construction.
module sr_pwm_driver
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic             s,
    output logic             r,
    output logic             period_done,
    output logic             cfg_err,
    output logic             busy
);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] per_a;
    logic [WIDTH-1:0] duty_a;
    logic             pending;
    logic             apply;
    logic             at_end;
    logic             s_d;
    logic             r_d;
    logic             pd_d;
    logic             err_d;

    sr_cfg_shadow #(
        .WIDTH (WIDTH)
    ) u_cfg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .period  (period),
        .duty    (duty),
        .apply   (apply),
        .per_a   (per_a),
        .duty_a  (duty_a),
        .pending (pending)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, counter and next pulse values from the current cnt.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        s_d     = 1'b0;
        r_d     = 1'b0;
        pd_d    = 1'b0;
        err_d   = 1'b0;
        apply   = 1'b0;
        at_end  = (cnt == per_a);
        unique case (state)
            IDLE: begin
                apply = pending;
                cnt_d = '0;
                if (en) begin
                    if (per_a != '0) begin
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    r_d     = 1'b1;
                end else begin
                    apply = at_end;
                    pd_d  = at_end;
                    cnt_d = at_end ? '0 : cnt + WIDTH'(1);
                    s_d   = (cnt == '0) && (duty_a != '0);
                    r_d   = ((cnt == '0) && (duty_a == '0))
                          || ((duty_a != '0) && (cnt == duty_a)
                              && (duty_a <= per_a));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered counter and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            s           <= 1'b0;
            r           <= 1'b0;
            period_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            s           <= s_d;
            r           <= r_d;
            period_done <= pd_d;
            cfg_err     <= err_d;
        end
    end

    assign busy = (state == RUN);

endmodule
